// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encodings and counter width helper shared by the UART blocks
package uart_pkg;
  typedef enum logic [2:0] {s_idle, s_start, s_data, s_stop, s_recover} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: RX FIFO write port plus frame status pulses
interface uart_rx_if #(parameter int P_BIT_CNT = 8);
  logic [P_BIT_CNT-1:0] fifo_wr_data;
  logic fifo_wr_en;
  logic fifo_full;
  logic frame_err;
  logic overrun;
  modport master(output fifo_wr_data, fifo_wr_en, frame_err, overrun, input fifo_full);
  modport slave(input fifo_wr_data, fifo_wr_en, frame_err, overrun, output fifo_full);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input with a chosen reset value
module sync_2ff #(parameter logic P_RST_VAL = 1'b1) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic meta;
  always_ff @(posedge i_clk) begin
    if (i_rst) {o_q, meta} <= {P_RST_VAL, P_RST_VAL};
    else {o_q, meta} <= {meta, i_d};
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver feeding the RX FIFO one word per good frame
module uart_rx
  import uart_pkg::*;
#(
  parameter int P_DELAY_CNT = 868,
  parameter int P_BIT_CNT   = 8
) (
  input logic i_clk,
  input logic i_rst,
  input logic i_sig,
  uart_rx_if.master rx
);
  localparam int DW = cnt_w(P_DELAY_CNT);
  localparam int BW = cnt_w(P_BIT_CNT);
  logic s, tick;
  state_t state, state_n;
  logic [DW-1:0] dly, dly_n;
  logic [BW-1:0] bits, bits_n;
  logic [P_BIT_CNT-1:0] sh, sh_n, data, data_n;
  logic wr, wr_n, ferr, ferr_n, ovr, ovr_n;
  sync_2ff #(.P_RST_VAL(1'b1)) u_sync (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_sig), .o_q(s));
  assign tick = dly == DW'(1);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= s_idle;
      dly   <= '0;
      bits  <= '0;
      sh    <= '0;
      data  <= '0;
      {wr, ferr, ovr} <= '0;
    end else begin
      state <= state_n;
      dly   <= dly_n;
      bits  <= bits_n;
      sh    <= sh_n;
      data  <= data_n;
      {wr, ferr, ovr} <= {wr_n, ferr_n, ovr_n};
    end
  end
  always_comb begin
    state_n = state;
    dly_n   = (dly > DW'(1)) ? dly - DW'(1) : dly;
    bits_n  = bits;
    sh_n    = sh;
    data_n  = data;
    wr_n    = 1'b0;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;
    case (state)
      s_idle: if (!s) begin
        dly_n   = DW'(P_DELAY_CNT / 2);
        state_n = s_start;
      end
      s_start: if (tick) begin
        dly_n   = DW'(P_DELAY_CNT);
        bits_n  = BW'(P_BIT_CNT);
        state_n = s ? s_idle : s_data;
      end
      s_data: if (tick) begin
        sh_n    = {s, sh[P_BIT_CNT-1:1]};
        bits_n  = bits - BW'(1);
        dly_n   = DW'(P_DELAY_CNT);
        state_n = (bits == BW'(1)) ? s_stop : s_data;
      end
      s_stop: if (tick) begin
        wr_n    = s & ~rx.fifo_full;
        ovr_n   = s & rx.fifo_full;
        ferr_n  = ~s;
        data_n  = wr_n ? sh : data;
        state_n = s ? s_idle : s_recover;
      end
      s_recover: state_n = s ? s_idle : s_recover;
      default: state_n = s_idle;
    endcase
  end
  assign rx.fifo_wr_data = data;
  assign rx.fifo_wr_en   = wr;
  assign rx.frame_err    = ferr;
  assign rx.overrun      = ovr;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 8 clocks per bit, 8 data bits
module tb_uart_rx;
  localparam int K_WR = 1, K_FERR = 2, K_OVR = 3;
  typedef struct {int kind; logic [7:0] data; longint cyc;} exp_t;
  logic clk = 0, rst = 1, i_sig = 1;
  longint cyc = 0;
  int n_tests = 0, n_fail = 0;
  logic [7:0] last_wr = 8'h00;
  exp_t q[$];
  uart_rx_if #(.P_BIT_CNT(8)) rx();
  uart_rx #(.P_DELAY_CNT(8), .P_BIT_CNT(8)) dut (.i_clk(clk), .i_rst(rst), .i_sig(i_sig), .rx(rx));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_ev(input int kind, input logic [7:0] d, input longint at);
    exp_t e;
    e.kind = kind;
    e.data = d;
    e.cyc  = at;
    q.push_back(e);
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    i_sig = 0;
    wait_cyc(8);
    for (int i = 0; i < 8; i++) begin
      i_sig = d[i];
      wait_cyc(8);
    end
    i_sig = stop;
    wait_cyc(8);
  endtask
  task automatic send_ok(input logic [7:0] d);
    expect_ev(K_WR, d, -1);
    last_wr = d;
    send(d, 1'b1);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      int np, kind;
      exp_t e;
      np   = int'(rx.fifo_wr_en) + int'(rx.frame_err) + int'(rx.overrun);
      kind = rx.fifo_wr_en ? K_WR : rx.frame_err ? K_FERR : rx.overrun ? K_OVR : 0;
      if (np > 1) check("pulse_onehot", np, 1);
      if (np != 0) begin
        if (q.size() == 0) check("unexpected_pulse", kind, 0);
        else begin
          e = q.pop_front();
          check("pulse_kind", kind, e.kind);
          check("wr_data", rx.fifo_wr_data, e.data);
          if (e.cyc >= 0) check("latency", cyc, e.cyc);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d expectations pending", q.size());
    $fatal(1, "timeout");
  end
  initial begin
    rx.fifo_full = 0;
    wait_cyc(3);
    check("rst_wr_en", rx.fifo_wr_en, 0);
    check("rst_frame_err", rx.frame_err, 0);
    check("rst_overrun", rx.overrun, 0);
    check("rst_wr_data", rx.fifo_wr_data, 0);
    rst = 0;
    wait_cyc(5);
    // frame 0xA5 with exact arrival cycle: 2 sync + 4 half bit + 72 + 1
    expect_ev(K_WR, 8'hA5, cyc + 79);
    last_wr = 8'hA5;
    send(8'hA5, 1'b1);
    wait_cyc(10);
    check("a5_drained", q.size(), 0);
    // short glitch must be ignored entirely
    i_sig = 0;
    wait_cyc(3);
    i_sig = 1;
    wait_cyc(20);
    check("glitch_no_pulse", q.size(), 0);
    send_ok(8'h5A);
    wait_cyc(10);
    // bad stop bit followed by a break, then a good frame
    expect_ev(K_FERR, last_wr, -1);
    send(8'h3C, 1'b0);
    wait_cyc(40);
    i_sig = 1;
    wait_cyc(16);
    check("break_only_ferr", q.size(), 0);
    send_ok(8'h81);
    wait_cyc(10);
    // overrun keeps the last written word on the data port
    rx.fifo_full = 1;
    expect_ev(K_OVR, last_wr, -1);
    send(8'h55, 1'b1);
    wait_cyc(4);
    rx.fifo_full = 0;
    check("ovr_data_hold", rx.fifo_wr_data, 8'h81);
    wait_cyc(6);
    send_ok(8'h66);
    wait_cyc(10);
    // reset in the middle of data bit 4
    i_sig = 0;
    wait_cyc(8);
    for (int i = 0; i < 4; i++) begin
      i_sig = 1'(8'hF0 >> i);
      wait_cyc(8);
    end
    i_sig = 1;
    wait_cyc(4);
    rst = 1;
    wait_cyc(1);
    rst = 0;
    check("midrst_wr_en", rx.fifo_wr_en, 0);
    check("midrst_frame_err", rx.frame_err, 0);
    check("midrst_overrun", rx.overrun, 0);
    check("midrst_wr_data", rx.fifo_wr_data, 0);
    last_wr = 8'h00;
    wait_cyc(50);
    check("midrst_no_pulse", q.size(), 0);
    send_ok(8'h0F);
    wait_cyc(10);
    // back-to-back frames with no idle gap
    send_ok(8'h00);
    send_ok(8'hFF);
    send_ok(8'h80);
    wait_cyc(20);
    check("final_wr_data", rx.fifo_wr_data, 8'h80);
    check("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
